cook_timer_ctrl: RTL
====================

// Module: cook_timer_ctrl
// PURPOSE
//  Sequencer for the microwave countdown chain (min mod10, sec-tens mod6, sec-ones mod10).
//  Captures keypad digits into a 3-digit preset and parallel-loads the chain via loadn.
//  Gates the chain enable with the 1 Hz tick and drives the magnetron.
//  Stops on door-open/stop and flags completion from the chain's all-zero signal.
// PARAMETERS
//  DONE_TICKS    3  number of tick pulses for which done stays high before returning to IDLE
//  SEC_TENS_MAX  5  largest legal seconds-tens digit; higher values make the preset invalid
// PORTS
//  clk           in   1  system clock, rising edge
//  clrn          in   1  reset, asynchronous, active-low
//  tick          in   1  one-cycle 1 Hz strobe, synchronous to clk
//  key_valid     in   1  one-cycle strobe: key_digit is valid
//  key_digit     in   4  keypad digit; values >9 are ignored
//  start         in   1  one-cycle start strobe
//  stop          in   1  one-cycle stop/pause strobe
//  clear         in   1  one-cycle clear strobe
//  door_closed   in   1  level, 1 = door closed
//  cnt_zero      in   1  chain all-digits-zero (AND of digit zero outputs)
//  preset_min    out  4  load data, minutes digit
//  preset_tens   out  4  load data, seconds-tens digit
//  preset_ones   out  4  load data, seconds-ones digit
//  cnt_loadn     out  1  active-low parallel load to the chain
//  cnt_en        out  1  chain count enable
//  mag_on        out  1  magnetron drive
//  done          out  1  cooking-complete indicator
//  state         out  3  current state, for display/debug
// BEHAVIOUR
//  States: IDLE=0 ENTRY=1 LOAD=2 COOK=3 PAUSE=4 DONE=5. Codes 6/7 are illegal and go to IDLE.
//  Reset (clrn=0, async):
//   - state=IDLE, presets=0, cnt_loadn=1, cnt_en=0, mag_on=0, done=0, tick counter=0.
//  Event priority, same cycle: clear > stop | !door_closed > start > key_valid.
//  Digit shift, on key_valid with key_digit<=9:
//   - min<=tens, tens<=ones, ones<=key_digit; the old min digit is discarded.
//  IDLE:
//   - legal key shifts the digit in, then -> ENTRY.
//   - start is ignored.
//  ENTRY:
//   - legal key shifts the digit in.
//   - clear -> presets=0, -> IDLE.
//   - start -> LOAD only if door_closed, preset!=000 and preset_tens<=SEC_TENS_MAX; otherwise no effect.
//  LOAD (exactly 1 cycle):
//   - cnt_loadn=0; chain captures the presets on the closing edge; -> COOK.
//  COOK:
//   - mag_on=1; cnt_en = tick (combinational, same cycle); key_valid ignored.
//   - cnt_zero=1 -> DONE. cnt_zero wins over stop/door on the same cycle.
//   - stop or !door_closed -> PAUSE.
//   - clear -> presets=0, -> IDLE.
//  PAUSE:
//   - mag_on=0, cnt_en=0; ticks and keys ignored.
//   - start with door_closed -> COOK with no reload; the chain resumes from its held value.
//   - clear -> presets=0, -> IDLE.
//  DONE:
//   - done=1; counts ticks. After DONE_TICKS ticks -> IDLE, presets=0, tick counter=0.
//   - clear, stop or key_valid -> IDLE at once; that key is dropped.
//  Timing:
//   - cnt_loadn, mag_on, done and state are decoded from the state register (no input-to-output path).
//   - cnt_en is the only combinational input->output path: cnt_en = (state==COOK) & tick.
//   - A tick arriving on the cycle stop is seen is still counted (state is COOK that cycle).
//  Mid-operation reset:
//   - clrn low in any state forces the reset values immediately, with no clock required.
//   - cnt_loadn is released to 1; the chain's own clrn clears the chain.
// STRUCTURE
//  Package cook_timer_pkg:
//   - state localparams (S_IDLE..S_DONE), DIGIT_MAX=9, state width=3.
//  Sub-module preset_shift_reg:
//   - 3 x 4-bit digit shifter; inputs shift_en, digit, clr; outputs the three digits; async clrn.
//  Top level: state register, next-state logic, done tick counter ($clog2(DONE_TICKS+1) bits), output decode.
// TESTING
//  1 clrn=0 at t=0, released at 5 ns -> state=0, presets=000, cnt_loadn=1, cnt_en=0, mag_on=0, done=0.
//  2 keys 1,3,0 then start, door_closed=1 -> presets 1/3/0; cnt_loadn=0 for 1 cycle; state=3;
//    mag_on=1; cnt_en high only on tick cycles.
//  3 keys 0,7,5 then start -> tens=7 is rejected, state stays 1; key 0xA -> presets unchanged.
//  4 in COOK, drop door_closed -> state=4 next cycle, mag_on=0, ticks give cnt_en=0;
//    close door + start -> state=3, no cnt_loadn pulse.
//  5 in COOK, cnt_zero=1 -> state=5, done=1 for exactly 3 ticks, then state=0 and presets=000.
//  6 cnt_zero and stop on the same cycle -> DONE.
//    clear during ENTRY -> state=0, presets=000.
//    clrn pulse during COOK -> immediate reset values.

Source files
------------

// File: rtl/cook_timer_pkg.sv
// Shared constants for the microwave cook-timer sequencer: state codes,
// digit width and the keypad digit legality check.
`timescale 1ns/1ps
package cook_timer_pkg;

  localparam int STATE_W = 3;
  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] S_ENTRY = 3'd1;
  localparam logic [STATE_W-1:0] S_LOAD  = 3'd2;
  localparam logic [STATE_W-1:0] S_COOK  = 3'd3;
  localparam logic [STATE_W-1:0] S_PAUSE = 3'd4;
  localparam logic [STATE_W-1:0] S_DONE  = 3'd5;

  function automatic logic digit_legal(input logic [DIGIT_W-1:0] d);
    return (d <= DIGIT_MAX);
  endfunction

endpackage

// File: rtl/cook_timer_ctrl_preset_shift_reg.sv
// Three-digit keypad preset register (minutes, seconds-tens, seconds-ones).
// New digits enter at the ones position; clr has priority over a shift.
`timescale 1ns/1ps
module preset_shift_reg
  import cook_timer_pkg::*;
(
  input  logic               clk,
  input  logic               clrn,
  input  logic               shift_en,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               clr,
  output logic [DIGIT_W-1:0] min_digit,
  output logic [DIGIT_W-1:0] tens_digit,
  output logic [DIGIT_W-1:0] ones_digit
);

  // digit storage: clear, shift left by one digit, or hold
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      min_digit  <= 4'd0;
      tens_digit <= 4'd0;
      ones_digit <= 4'd0;
    end else if (clr) begin
      min_digit  <= 4'd0;
      tens_digit <= 4'd0;
      ones_digit <= 4'd0;
    end else if (shift_en) begin
      min_digit  <= tens_digit;
      tens_digit <= ones_digit;
      ones_digit <= digit;
    end else begin
      min_digit  <= min_digit;
      tens_digit <= tens_digit;
      ones_digit <= ones_digit;
    end
  end

endmodule

// File: rtl/cook_timer_ctrl.sv
// Microwave countdown sequencer: keypad entry, chain load, tick-gated cooking,
// pause on door/stop and a timed completion indication.
`timescale 1ns/1ps
module cook_timer_ctrl
  import cook_timer_pkg::*;
#(
  parameter int DONE_TICKS   = 3,
  parameter int SEC_TENS_MAX = 5
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic               tick,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_digit,
  input  logic               start,
  input  logic               stop,
  input  logic               clear,
  input  logic               door_closed,
  input  logic               cnt_zero,
  output logic [DIGIT_W-1:0] preset_min,
  output logic [DIGIT_W-1:0] preset_tens,
  output logic [DIGIT_W-1:0] preset_ones,
  output logic               cnt_loadn,
  output logic               cnt_en,
  output logic               mag_on,
  output logic               done,
  output logic [STATE_W-1:0] state
);

  localparam int TCNT_W = $clog2(DONE_TICKS + 1);
  localparam logic [TCNT_W-1:0]  TCNT_LAST = TCNT_W'(DONE_TICKS - 1);
  localparam logic [DIGIT_W-1:0] TENS_MAX  = DIGIT_W'(SEC_TENS_MAX);

  logic [STATE_W-1:0] state_r;
  logic [STATE_W-1:0] state_nxt_s;
  logic [TCNT_W-1:0]  tick_cnt_r;
  logic [TCNT_W-1:0]  tick_cnt_nxt_s;
  logic               shift_en_s;
  logic               clr_s;
  logic               key_ok_s;
  logic               start_ok_s;

  assign key_ok_s   = key_valid & digit_legal(key_digit);
  assign start_ok_s = start & door_closed
                    & ({preset_min, preset_tens, preset_ones} != 12'd0)
                    & (preset_tens <= TENS_MAX);

  preset_shift_reg u_presets (
    .clk        (clk),
    .clrn       (clrn),
    .shift_en   (shift_en_s),
    .digit      (key_digit),
    .clr        (clr_s),
    .min_digit  (preset_min),
    .tens_digit (preset_tens),
    .ones_digit (preset_ones)
  );

  // state register and done-phase tick counter
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_r    <= S_IDLE;
      tick_cnt_r <= {TCNT_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      tick_cnt_r <= tick_cnt_nxt_s;
    end
  end

  // next state, preset shift/clear and tick counter update
  always_comb begin
    state_nxt_s    = state_r;
    tick_cnt_nxt_s = {TCNT_W{1'b0}};
    shift_en_s     = 1'b0;
    clr_s          = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (clear) begin
          clr_s = 1'b1;
        end else if (key_ok_s) begin
          shift_en_s  = 1'b1;
          state_nxt_s = S_ENTRY;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_ENTRY: begin
        if (clear) begin
          clr_s       = 1'b1;
          state_nxt_s = S_IDLE;
        end else if (start_ok_s) begin
          state_nxt_s = S_LOAD;
        end else if (key_ok_s) begin
          shift_en_s = 1'b1;
        end else begin
          state_nxt_s = S_ENTRY;
        end
      end
      S_LOAD: state_nxt_s = S_COOK;
      S_COOK: begin
        // the chain reaching zero outranks a same-cycle stop or door opening
        if (clear) begin
          clr_s       = 1'b1;
          state_nxt_s = S_IDLE;
        end else if (cnt_zero) begin
          state_nxt_s = S_DONE;
        end else if (stop || !door_closed) begin
          state_nxt_s = S_PAUSE;
        end else begin
          state_nxt_s = S_COOK;
        end
      end
      S_PAUSE: begin
        if (clear) begin
          clr_s       = 1'b1;
          state_nxt_s = S_IDLE;
        end else if (start && door_closed) begin
          state_nxt_s = S_COOK;
        end else begin
          state_nxt_s = S_PAUSE;
        end
      end
      S_DONE: begin
        if (clear || stop || key_ok_s) begin
          clr_s       = 1'b1;
          state_nxt_s = S_IDLE;
        end else if (tick) begin
          if (tick_cnt_r == TCNT_LAST) begin
            clr_s       = 1'b1;
            state_nxt_s = S_IDLE;
          end else begin
            tick_cnt_nxt_s = tick_cnt_r + TCNT_W'(1);
          end
        end else begin
          tick_cnt_nxt_s = tick_cnt_r;
        end
      end
      default: begin
        clr_s       = 1'b1;
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // outputs decoded from the state register; only cnt_en sees an input
  always_comb begin
    state     = state_r;
    cnt_loadn = 1'b1;
    cnt_en    = 1'b0;
    mag_on    = 1'b0;
    done      = 1'b0;
    case (state_r)
      S_LOAD: cnt_loadn = 1'b0;
      S_COOK: begin
        mag_on = 1'b1;
        cnt_en = tick;
      end
      S_DONE:  done = 1'b1;
      default: cnt_loadn = 1'b1;
    endcase
  end

endmodule
